// File: rtl/rv32_mem_unit_if.sv
//------------------------------------------------------------------------------
// Module : rv32_mem_unit_if (with package rv32_mem_pkg)
// Brief  : Request types and pipeline/data-bus signal bundle for rv32_mem_unit.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32_mem_pkg;
    typedef logic [31:0] rv32_word;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_t;

    typedef struct packed {
        rv32_word addr;
        rv32_word data;
        mem_op_t  op;
    } memory_request_t;
endpackage

interface rv32_mem_unit_if;
    import rv32_mem_pkg::*;

    logic            req_valid;
    memory_request_t req;
    logic            req_ready;
    logic            stall;
    logic            load_valid;
    rv32_word        load_data;
    logic            misaligned;
    logic            bus_req;
    logic            bus_we;
    logic [31:0]     bus_addr;
    logic [3:0]      bus_be;
    logic [31:0]     bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [31:0]     bus_rdata;

    // slave: the memory unit; master: pipeline stage plus bus fabric
    modport slave (
        input  req_valid, req, bus_gnt, bus_rvalid, bus_rdata,
        output req_ready, stall, load_valid, load_data, misaligned,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output req_valid, req, bus_gnt, bus_rvalid, bus_rdata,
        input  req_ready, stall, load_valid, load_data, misaligned,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

`default_nettype wire

// File: rtl/rv32_mem_unit.sv
//------------------------------------------------------------------------------
// Module : rv32_mem_unit
// Brief  : Data-memory access unit: aligns, issues req/gnt/rvalid bus cycles, extends loads.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rv32_mem_unit
    import rv32_mem_pkg::*;
#(
    parameter bit TRAP_MISALIGNED = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rv32_mem_unit_if.slave mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    mem_op_t     r_op;
    logic [1:0]  r_off;
    logic        r_load_valid;
    logic        r_misaligned;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    rv32_word    r_load_data;

    logic        w_valid_op;
    logic        w_is_load;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_accept;
    logic        w_reject;
    logic        w_op_is_load;
    logic [31:0] w_shifted;
    rv32_word    w_load_ext;

    // Decode of the incoming request
    always_comb begin
        w_valid_op = 1'b0;
        w_is_load  = 1'b0;
        w_aligned  = 1'b1;
        w_be       = 4'b0000;
        w_wdata    = 32'd0;
        case (mem.req.op)
            MEM_LB, MEM_LBU: begin
                w_valid_op = 1'b1;
                w_is_load  = 1'b1;
                w_be       = 4'b0001 << mem.req.addr[1:0];
            end
            MEM_LH, MEM_LHU: begin
                w_valid_op = 1'b1;
                w_is_load  = 1'b1;
                w_aligned  = ~mem.req.addr[0];
                w_be       = 4'b0011 << mem.req.addr[1:0];
            end
            MEM_LW: begin
                w_valid_op = 1'b1;
                w_is_load  = 1'b1;
                w_aligned  = (mem.req.addr[1:0] == 2'b00);
                w_be       = 4'b1111;
            end
            MEM_SB: begin
                w_valid_op = 1'b1;
                w_be       = 4'b0001 << mem.req.addr[1:0];
                w_wdata    = {4{mem.req.data[7:0]}};
            end
            MEM_SH: begin
                w_valid_op = 1'b1;
                w_aligned  = ~mem.req.addr[0];
                w_be       = 4'b0011 << mem.req.addr[1:0];
                w_wdata    = {2{mem.req.data[15:0]}};
            end
            MEM_SW: begin
                w_valid_op = 1'b1;
                w_aligned  = (mem.req.addr[1:0] == 2'b00);
                w_be       = 4'b1111;
                w_wdata    = mem.req.data;
            end
            default: ;
        endcase
    end

    // Next state and combinational pipeline handshake
    always_comb begin
        w_accept     = (r_state == S_IDLE) && mem.req_valid && w_valid_op && w_aligned;
        w_reject     = (r_state == S_IDLE) && mem.req_valid && w_valid_op && !w_aligned;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept)       w_next_state = S_REQ;
            S_REQ:  if (mem.bus_gnt)    w_next_state = S_WAIT;
            S_WAIT: if (mem.bus_rvalid) w_next_state = S_RESP;
            S_RESP: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        mem.req_ready = (r_state == S_IDLE);
        mem.stall     = (r_state == S_REQ) || (r_state == S_WAIT) || w_accept;
    end

    // Load alignment and extension from the latched op/offset
    always_comb begin
        w_op_is_load = (r_op == MEM_LB) || (r_op == MEM_LBU) || (r_op == MEM_LH) ||
                       (r_op == MEM_LHU) || (r_op == MEM_LW);
        w_shifted    = mem.bus_rdata >> {r_off, 3'b000};
        case (r_op)
            MEM_LB:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_LBU: w_load_ext = {24'd0, w_shifted[7:0]};
            MEM_LH:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_LHU: w_load_ext = {16'd0, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= MEM_NOP;
            r_off        <= 2'b00;
            r_load_valid <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_be     <= 4'b0000;
            r_bus_addr   <= 32'd0;
            r_bus_wdata  <= 32'd0;
            r_load_data  <= 32'd0;
        end else begin
            r_misaligned <= w_reject && TRAP_MISALIGNED;
            r_load_valid <= (r_state == S_WAIT) && mem.bus_rvalid && w_op_is_load;
            if (w_accept) begin
                r_op        <= mem.req.op;
                r_off       <= mem.req.addr[1:0];
                r_bus_req   <= 1'b1;
                r_bus_we    <= ~w_is_load;
                r_bus_be    <= w_be;
                r_bus_addr  <= {mem.req.addr[31:2], 2'b00};
                r_bus_wdata <= w_wdata;
            end else if ((r_state == S_REQ) && mem.bus_gnt) begin
                r_bus_req   <= 1'b0;
            end
            if ((r_state == S_WAIT) && mem.bus_rvalid && w_op_is_load)
                r_load_data <= w_load_ext;
        end
    end

    assign mem.load_valid = r_load_valid;
    assign mem.load_data  = r_load_data;
    assign mem.misaligned = r_misaligned;
    assign mem.bus_req    = r_bus_req;
    assign mem.bus_we     = r_bus_we;
    assign mem.bus_be     = r_bus_be;
    assign mem.bus_addr   = r_bus_addr;
    assign mem.bus_wdata  = r_bus_wdata;

endmodule

`default_nettype wire

// File: doc/rv32_mem_unit.md
# rv32_mem_unit

Data-memory access unit between the pipeline memory stage and the external data bus. It accepts one `memory_request_t` (addr, data, op) at a time and drives a req/gnt/rvalid bus with a word-aligned address, byte enables and replicated write data. For loads it returns sign- or zero-extended data, and it stalls the pipeline while a transaction is outstanding. Misaligned accesses are flagged and never reach the bus.

## Interface
- `TRAP_MISALIGNED`, default 1: when 1, misaligned requests pulse `misaligned` and are dropped; when 0, they are dropped silently.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: the memory stage presents `req`.
- `req` in `memory_request_t`: addr, data and op (`mem_op_t`).
- `req_ready` out 1: unit idle; the request is accepted this cycle.
- `stall` out 1: freeze the upstream pipeline.
- `load_valid` out 1: one-cycle pulse; `load_data` is valid.
- `load_data` out 32: aligned, extended load result (`rv32_word`).
- `misaligned` out 1: one-cycle pulse on a rejected misaligned request.
- `bus_req` out 1: bus request.
- `bus_we` out 1: 1 for store, 0 for load.
- `bus_addr` out 32: `{req.addr[31:2], 2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: store data.
- `bus_gnt` in 1: bus accepted the request.
- `bus_rvalid` in 1: response or write acknowledge.
- `bus_rdata` in 32: read data.

## Operation
- FSM states:
  - IDLE: accept a request here.
  - REQ: `bus_req` high.
  - WAIT: granted, awaiting `bus_rvalid`.
  - RESP: `load_valid` cycle.
- Acceptance, in IDLE with `req_valid`:
  - `op == MEM_NOP`, or an encoding not in `mem_op_t`: ignored, stay in IDLE.
  - Alignment check: LH/LHU/SH require `addr[0]==0`; LW/SW require `addr[1:0]==0`; LB/LBU/SB are always aligned.
  - Misaligned: `misaligned` pulses next cycle (if `TRAP_MISALIGNED`), stay in IDLE, no bus activity.
  - Aligned: latch op and `addr[1:0]`, register the bus outputs, go to REQ.
- Byte enables, `off = addr[1:0]`:
  - SB/LB/LBU: `4'b0001 << off`.
  - SH/LH/LHU: `4'b0011 << off`.
  - SW/LW: `4'b1111`.
- Write data:
  - SB: `{4{data[7:0]}}`.
  - SH: `{2{data[15:0]}}`.
  - SW: `data`.
  - Loads: `bus_wdata = 0`.
- REQ: `bus_req`, `bus_addr`, `bus_be`, `bus_we` and `bus_wdata` are held stable until `bus_gnt`; on `bus_gnt`, drop `bus_req` and go to WAIT.
- WAIT: on `bus_rvalid` go to RESP.
  - Loads also capture `r = bus_rdata >> (8*off)`.
  - LB: `{{24{r[7]}},r[7:0]}`.
  - LBU: `{24'b0,r[7:0]}`.
  - LH: `{{16{r[15]}},r[15:0]}`.
  - LHU: `{16'b0,r[15:0]}`.
  - LW: `r`.
- RESP: `load_valid=1` for loads only (stores: 0); return to IDLE.
- `bus_rvalid` outside WAIT is ignored.
- `bus_gnt` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `load_valid`, `misaligned`, `bus_req`, `bus_we` = 0; `bus_be` = 0; `load_data`, `bus_addr`, `bus_wdata` = 0.
- `req_ready = (state==IDLE)`, combinational.
- `stall` is combinational and high when either holds:
  - state is REQ or WAIT;
  - state is IDLE with `req_valid`, an aligned non-NOP op.
- `stall` is low in RESP, so the pipeline advances while capturing `load_data`.
- Cycle n: accept. Cycle n+1: `bus_req=1`. Minimum latency, with `bus_gnt` at n+1 and `bus_rvalid` at n+2: `load_valid` at n+3.
- The bus guarantees `bus_rvalid` no earlier than the cycle after `bus_gnt`.
- `load_data` holds its value until the next load completes.
- Back-to-back requests: the next acceptance is possible in the cycle after RESP (IDLE). Maximum throughput is one access per 4 cycles.
- Reset mid-transaction, in REQ or WAIT: next edge gives IDLE, `bus_req=0`, no `load_valid`. A late `bus_rvalid` is ignored.

## Test plan
- LB at addr 0x103, `bus_rdata`=0x80FF1234 -> `bus_be`=1000, `bus_addr`=0x100; `load_data`=0xFFFFFF80 with a `load_valid` pulse, 3 cycles after acceptance.
- LHU at 0x102, `bus_rdata`=0x80010000 -> `bus_be`=1100, `load_data`=0x00008001. LH at the same address gives 0xFFFF8001.
- SB at addr 0x101, data 0x000000AB -> `bus_we`=1, `bus_be`=0010, `bus_wdata`=0xABABABAB, `bus_addr`=0x100; no `load_valid`; `stall` drops after `bus_rvalid`.
- LW at 0x102 and SH at 0x001 -> `misaligned` pulses, `bus_req` stays 0, `stall` stays 0. Repeat with `TRAP_MISALIGNED`=0: no pulse.
- LW at 0x200 with `bus_gnt` delayed 3 cycles and `bus_rvalid` 2 cycles later -> bus outputs stable throughout REQ, `stall` high every cycle until RESP, `load_data`=`bus_rdata`.
- `rst` asserted in WAIT, then `bus_rvalid` arrives -> no `load_valid`; all outputs at reset values; the next request completes normally.
